// File: rtl/fpu_compare_sequencer.sv
// fpu_compare_sequencer
// Drives the shared arithmetic unit for the FCOM/FCOMP/FCOMPP/FUCOM family.
// NaN operands are resolved locally. Ordered operands go to the unit as a
// SUB, and its compare flags are mapped onto C3/C2/C0. Any stack pops are
// then issued, and the result is presented to the core in a single done cycle.
//
// Optional feature: define FPU_CMP_TIMEOUT_EN to add a WAIT-state watchdog
// that forces an unordered/invalid result after TIMEOUT_CYCLES cycles.
module fpu_compare_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  pop_count,
    input  logic        unordered_ok,
    input  logic [79:0] operand_a,
    input  logic [79:0] operand_b,
    output logic        busy,
    output logic        done,
    output logic        arith_enable,
    output logic [3:0]  arith_operation,
    output logic [79:0] arith_operand_a,
    output logic [79:0] arith_operand_b,
    input  logic        arith_done,
    input  logic        arith_cc_equal,
    input  logic        arith_cc_less,
    input  logic        arith_cc_greater,
    input  logic        arith_cc_unordered,
    output logic        cc_c3,
    output logic        cc_c2,
    output logic        cc_c1,
    output logic        cc_c0,
    output logic        invalid,
    output logic        pop_req
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_POP   = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    localparam logic [3:0] OP_SUB = 4'd1;

    state_e      state_q, state_d;

    // Latched command
    logic [79:0] opa_q, opa_d;
    logic [79:0] opb_q, opb_d;
    logic [1:0]  pops_q, pops_d;
    logic        uok_q, uok_d;

    // Result staged until the done cycle
    logic        res_c3_q, res_c3_d;
    logic        res_c2_q, res_c2_d;
    logic        res_c0_q, res_c0_d;
    logic        res_inv_q, res_inv_d;

    // Architecturally visible condition codes; change only on entry to DONE
    logic        cc_c3_q, cc_c2_q, cc_c0_q, inv_q;

    // Operand classification on the latched values
    logic        nan_a, nan_b, snan_a, snan_b, nan_any, snan_any;
    logic [1:0]  flag_cnt;
    logic        flags_ok;
    logic        resp_evt;
    logic        tmo_hit;

    // Extended real: sign[79], exponent[78:64], explicit integer bit[63],
    // fraction[62:0]. The quiet bit is bit 62.
    assign nan_a    = (opa_q[78:64] == 15'h7FFF) && (opa_q[62:0] != 63'd0);
    assign nan_b    = (opb_q[78:64] == 15'h7FFF) && (opb_q[62:0] != 63'd0);
    assign snan_a   = nan_a && !opa_q[62];
    assign snan_b   = nan_b && !opb_q[62];
    assign nan_any  = nan_a || nan_b;
    assign snan_any = snan_a || snan_b;

    // A well-formed answer from the unit has exactly one ordering flag set
    // and no unordered indication.
    assign flag_cnt = {1'b0, arith_cc_equal} + {1'b0, arith_cc_less} + {1'b0, arith_cc_greater};
    assign flags_ok = !arith_cc_unordered && (flag_cnt == 2'd1);

    // Illegal watchdog limits leave this marker block in the elaborated hierarchy.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_timeout_cycles_illegal
    end

`ifdef FPU_CMP_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_q, tmo_d;

    // The counter runs only while waiting on the unit and restarts on every
    // entry to WAIT.
    always_comb begin
        tmo_d = 8'd0;
        if (state_q == S_WAIT) tmo_d = tmo_q + 8'd1;
    end

    // Watchdog counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tmo_q <= 8'd0;
        else          tmo_q <= tmo_d;
    end

    // A strobe that arrives in the final WAIT cycle still takes priority.
    assign tmo_hit = (state_q == S_WAIT) && !arith_done && (tmo_q == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    // The arithmetic unit answered, or the watchdog gave up on it.
    assign resp_evt = (state_q == S_WAIT) && (arith_done || tmo_hit);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CHECK;
            S_CHECK: begin
                if (nan_any) state_d = (pops_q != 2'd0) ? S_POP : S_DONE;
                else         state_d = S_ISSUE;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (resp_evt) state_d = (pops_q != 2'd0) ? S_POP : S_DONE;
            S_POP:   if (pops_q == 2'd1) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        busy         = (state_q != S_IDLE);
        done         = (state_q == S_DONE);
        arith_enable = (state_q == S_ISSUE);
        pop_req      = (state_q == S_POP);
    end

    // Command latch, pop countdown and result staging
    always_comb begin
        opa_d     = opa_q;
        opb_d     = opb_q;
        pops_d    = pops_q;
        uok_d     = uok_q;
        res_c3_d  = res_c3_q;
        res_c2_d  = res_c2_q;
        res_c0_d  = res_c0_q;
        res_inv_d = res_inv_q;

        if (state_q == S_IDLE && start) begin
            opa_d  = operand_a;
            opb_d  = operand_b;
            uok_d  = unordered_ok;
            // FCOMPP encoding 3 behaves like 2.
            pops_d = (pop_count == 2'd3) ? 2'd2 : pop_count;
        end

        if (state_q == S_POP) pops_d = pops_q - 2'd1;

        if (state_q == S_CHECK && nan_any) begin
            res_c3_d  = 1'b1;
            res_c2_d  = 1'b1;
            res_c0_d  = 1'b1;
            // FUCOM tolerates quiet NaNs; signalling NaNs are always invalid.
            res_inv_d = snan_any || !uok_q;
        end

        if (resp_evt) begin
            if (arith_done && flags_ok) begin
                res_c3_d  = arith_cc_equal;
                res_c2_d  = 1'b0;
                res_c0_d  = arith_cc_less;
                res_inv_d = 1'b0;
            end else begin
                res_c3_d  = 1'b1;
                res_c2_d  = 1'b1;
                res_c0_d  = 1'b1;
                res_inv_d = 1'b1;
            end
        end
    end

    // Datapath registers; visible flags load on the edge that enters DONE so
    // they change together with the done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opa_q     <= 80'd0;
            opb_q     <= 80'd0;
            pops_q    <= 2'd0;
            uok_q     <= 1'b0;
            res_c3_q  <= 1'b0;
            res_c2_q  <= 1'b0;
            res_c0_q  <= 1'b0;
            res_inv_q <= 1'b0;
            cc_c3_q   <= 1'b0;
            cc_c2_q   <= 1'b0;
            cc_c0_q   <= 1'b0;
            inv_q     <= 1'b0;
        end else begin
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            pops_q    <= pops_d;
            uok_q     <= uok_d;
            res_c3_q  <= res_c3_d;
            res_c2_q  <= res_c2_d;
            res_c0_q  <= res_c0_d;
            res_inv_q <= res_inv_d;
            if (state_d == S_DONE) begin
                cc_c3_q <= res_c3_d;
                cc_c2_q <= res_c2_d;
                cc_c0_q <= res_c0_d;
                inv_q   <= res_inv_d;
            end
        end
    end

    assign arith_operation = OP_SUB;
    assign arith_operand_a = opa_q;
    assign arith_operand_b = opb_q;
    assign cc_c3           = cc_c3_q;
    assign cc_c2           = cc_c2_q;
    assign cc_c1           = 1'b0;
    assign cc_c0           = cc_c0_q;
    assign invalid         = inv_q;

endmodule

// File: tb/tb_fpu_compare_sequencer.sv
// Bench for fpu_compare_sequencer: directed cases plus randomized compares
// checked against a result/latency model derived from the operand and flag rules.
// FPU_CMP_TIMEOUT_EN, when defined, also enables the watchdog cases.
module tb_fpu_compare_sequencer;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  pop_count = 2'd0;
    logic        unordered_ok = 1'b0;
    logic [79:0] operand_a = '0;
    logic [79:0] operand_b = '0;
    logic        arith_done = 1'b0;
    logic        f_eq = 1'b0, f_lt = 1'b0, f_gt = 1'b0, f_un = 1'b0;
    logic        busy, done, arith_enable, pop_req;
    logic [3:0]  arith_operation;
    logic [79:0] arith_operand_a, arith_operand_b;
    logic        cc_c3, cc_c2, cc_c1, cc_c0, invalid;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fpu_compare_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .start              (start),
        .pop_count          (pop_count),
        .unordered_ok       (unordered_ok),
        .operand_a          (operand_a),
        .operand_b          (operand_b),
        .busy               (busy),
        .done               (done),
        .arith_enable       (arith_enable),
        .arith_operation    (arith_operation),
        .arith_operand_a    (arith_operand_a),
        .arith_operand_b    (arith_operand_b),
        .arith_done         (arith_done),
        .arith_cc_equal     (f_eq),
        .arith_cc_less      (f_lt),
        .arith_cc_greater   (f_gt),
        .arith_cc_unordered (f_un),
        .cc_c3              (cc_c3),
        .cc_c2              (cc_c2),
        .cc_c1              (cc_c1),
        .cc_c0              (cc_c0),
        .invalid            (invalid),
        .pop_req            (pop_req)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_nan(input logic [79:0] x);
        return (x[78:64] == 15'h7FFF) && (x[62:0] != 63'd0);
    endfunction

    function automatic bit is_snan(input logic [79:0] x);
        return is_nan(x) && (x[62] == 1'b0);
    endfunction

    // Expected {C3,C2,C0,invalid}
    function automatic logic [3:0] model_res(input logic [79:0] a, input logic [79:0] b,
                                             input bit uok, input bit e, input bit l,
                                             input bit g, input bit u, input bit timed_out);
        int n;
        if (is_nan(a) || is_nan(b))
            return {3'b111, is_snan(a) || is_snan(b) || !uok};
        if (timed_out) return 4'b1111;
        n = int'(e) + int'(l) + int'(g);
        if (u || n != 1) return 4'b1111;
        return {e, 1'b0, l, 1'b0};
    endfunction

    function automatic logic [79:0] rand_op();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        case ($urandom_range(0, 5))
            0, 1: return {r[79], 15'($urandom_range(1, 32766)), 1'b1, r[62:0]};
            2:    return {r[79], 15'h7FFF, 2'b11, r[61:0]};
            3:    return {r[79], 15'h7FFF, 2'b10, r[61:1], 1'b1};
            4:    return {r[79], 15'h7FFF, 1'b1, 63'd0};
            default: return {r[79], 15'h7FFF, 1'b0, r[62:0]};
        endcase
    endfunction

    // One compare: drive, observe cycle by cycle, check against the model.
    // delay = cycles after the arith_enable cycle at which arith_done is given;
    // delay 0 means the unit never answers.
    task automatic run_cmp(input string nm, input logic [79:0] a, input logic [79:0] b,
                           input logic [1:0] pc, input bit uok,
                           input bit e, input bit l, input bit g, input bit u,
                           input int delay, input bit spurious, input bit start_busy);
        int exp_p, exp_done, done_cyc, en_cyc, en_cnt, pop_cnt, first_pop, last_pop, cyc;
        bit nan, busy_bad, stable_bad, idle_bad;
        logic [3:0] exp_r, got_r, op_cap;
        logic [79:0] opa_cap, opb_cap;

        exp_p = (pc == 2'd3) ? 2 : int'(pc);
        nan   = is_nan(a) || is_nan(b);
        exp_r = model_res(a, b, uok, e, l, g, u, delay == 0);
        if (nan)             exp_done = 2 + exp_p;
        else if (delay == 0) exp_done = 2 + TMO + exp_p + 1;
        else                 exp_done = 2 + delay + exp_p + 1;

        done_cyc = 0; en_cyc = 0; en_cnt = 0; pop_cnt = 0; first_pop = 0; last_pop = 0;
        busy_bad = 0; stable_bad = 0; idle_bad = 0;
        op_cap = '0; opa_cap = '0; opb_cap = '0;

        @(negedge clk);
        operand_a = a; operand_b = b; pop_count = pc; unordered_ok = uok; start = 1'b1;
        for (cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (!busy) busy_bad = 1;
            if (arith_enable) begin
                en_cnt++; en_cyc = cyc;
                op_cap = arith_operation; opa_cap = arith_operand_a; opb_cap = arith_operand_b;
            end
            if (en_cnt > 0 && (arith_operand_a !== a || arith_operand_b !== b)) stable_bad = 1;
            if (pop_req) begin
                pop_cnt++; last_pop = cyc;
                if (first_pop == 0) first_pop = cyc;
            end
            if (done) begin
                done_cyc = cyc;
                got_r = {cc_c3, cc_c2, cc_c0, invalid};
                chk({nm, ":c1"}, cc_c1, 1'b0);
                break;
            end
            // Inputs after the start edge must not leak into the compare.
            start = start_busy && (cyc == 1 || cyc == 2);
            operand_a = rand_op(); operand_b = rand_op(); pop_count = 2'($urandom);
            unordered_ok = 1'($urandom);
            if (en_cyc > 0 && delay > 0 && cyc == en_cyc + delay) begin
                arith_done = 1'b1; f_eq = e; f_lt = l; f_gt = g; f_un = u;
            end else if (spurious && cyc <= 2) begin
                arith_done = 1'b1; {f_eq, f_lt, f_gt, f_un} = 4'($urandom);
            end else begin
                arith_done = 1'b0; {f_eq, f_lt, f_gt, f_un} = 4'($urandom);
            end
        end
        start = 1'b0; arith_done = 1'b0;

        if (done_cyc == 0) begin
            chk({nm, ":done_seen"}, 1'b0, 1'b1);
            reset_n = 1'b0; @(negedge clk); reset_n = 1'b1;
            return;
        end
        chk({nm, ":latency"}, done_cyc, exp_done);
        chk({nm, ":c3_c2_c0_inv"}, got_r, exp_r);
        chk({nm, ":pops"}, pop_cnt, exp_p);
        if (exp_p > 0) begin
            chk({nm, ":pop_first"}, first_pop, done_cyc - exp_p);
            chk({nm, ":pop_last"}, last_pop, done_cyc - 1);
        end
        chk({nm, ":arith_en_cnt"}, en_cnt, nan ? 0 : 1);
        if (!nan) begin
            chk({nm, ":arith_en_cyc"}, en_cyc, 2);
            chk({nm, ":arith_op"}, op_cap, 4'd1);
            chk({nm, ":arith_opa"}, opa_cap, a);
            chk({nm, ":arith_opb"}, opb_cap, b);
            chk({nm, ":opnd_stable"}, stable_bad, 1'b0);
        end
        chk({nm, ":busy_while_active"}, busy_bad, 1'b0);

        // Afterwards: idle, no further done, flags held.
        repeat (3) begin
            @(negedge clk);
            if (busy || done || pop_req || arith_enable) idle_bad = 1;
            if ({cc_c3, cc_c2, cc_c0, invalid} !== exp_r) idle_bad = 1;
        end
        chk({nm, ":idle_hold"}, idle_bad, 1'b0);
    endtask

    localparam logic [79:0] ONE  = 80'h3FFF_8000000000000000;
    localparam logic [79:0] HALF = 80'h3FFE_8000000000000000;
    localparam logic [79:0] TWO  = 80'h4000_8000000000000000;
    localparam logic [79:0] QNAN = 80'h7FFF_C000000000000000;
    localparam logic [79:0] SNAN = 80'h7FFF_A000000000000000;

    initial begin
        bit bad;
        int d;
        logic [3:0] fl;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst:ctl", {busy, done, arith_enable, pop_req}, 4'b0000);
        chk("rst:cc", {cc_c3, cc_c2, cc_c1, cc_c0, invalid}, 5'b00000);
        chk("rst:op", arith_operation, 4'd1);
        chk("rst:opnd", {arith_operand_a, arith_operand_b}, 160'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_cmp("eq",     ONE,  ONE, 2'd0, 1'b0, 1, 0, 0, 0, 1, 0, 0);
        run_cmp("less",   HALF, ONE, 2'd0, 1'b0, 0, 1, 0, 0, 1, 0, 0);
        run_cmp("greater",TWO,  ONE, 2'd2, 1'b0, 0, 0, 1, 0, 3, 0, 0);
        run_cmp("qnan",   QNAN, ONE, 2'd0, 1'b1, 0, 0, 0, 0, 1, 0, 0);
        run_cmp("snan",   SNAN, ONE, 2'd0, 1'b1, 0, 0, 0, 0, 1, 0, 0);
        run_cmp("qnan_ord", ONE, QNAN, 2'd1, 1'b0, 0, 0, 0, 0, 1, 0, 0);
        run_cmp("eq_lt",  ONE,  ONE, 2'd0, 1'b0, 1, 1, 0, 0, 2, 0, 0);
        run_cmp("busy_start", TWO, HALF, 2'd1, 1'b0, 0, 0, 1, 0, 2, 1, 1);
        run_cmp("pc3",    HALF, TWO, 2'd3, 1'b0, 0, 1, 0, 0, 1, 0, 0);

        // Reset during WAIT, then a late arith_done in IDLE
        run_cmp("pre_rst", QNAN, ONE, 2'd0, 1'b0, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        operand_a = TWO; operand_b = ONE; pop_count = 2'd1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rstwait:ctl", {busy, done, arith_enable, pop_req}, 4'b0000);
        chk("rstwait:cc", {cc_c3, cc_c2, cc_c1, cc_c0, invalid}, 5'b00000);
        chk("rstwait:opnd", {arith_operand_a, arith_operand_b}, 160'd0);
        @(negedge clk);
        reset_n = 1'b1;
        arith_done = 1'b1; f_eq = 1'b1; f_lt = 1'b0; f_gt = 1'b0; f_un = 1'b0;
        @(negedge clk);
        arith_done = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy || done || pop_req || arith_enable || cc_c3) bad = 1;
        end
        chk("rstwait:late_done_ignored", bad, 1'b0);
        run_cmp("post_rst", ONE, TWO, 2'd0, 1'b0, 0, 1, 0, 0, 2, 0, 0);

`ifdef FPU_CMP_TIMEOUT_EN
        run_cmp("timeout",   ONE, TWO, 2'd0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        run_cmp("timeout_p", ONE, TWO, 2'd2, 1'b0, 0, 0, 0, 0, 0, 0, 0);
`endif

        // Randomized compares
        for (int t = 0; t < 200; t++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: fl = 4'b1000 >> $urandom_range(0, 2);
                6: fl = {3'b110 >> $urandom_range(0, 1), 1'b0};
                7: fl = 4'b0000;
                8: fl = 4'b0001 | 4'($urandom);
                default: fl = 4'($urandom);
            endcase
            d = int'($urandom_range(1, 8));
            run_cmp("rand", rand_op(), rand_op(), 2'($urandom), 1'($urandom),
                    fl[3], fl[2], fl[1], fl[0], d, 1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
